// File: rtl/uc_asteroide_if.sv
// Control/status bundle between the asteroid control FSM (master) and its datapath (slave).
interface uc_asteroide_if;
    // Datapath status
    logic       colisao_aste_com_nave;
    logic       rco_contador_aste;
    logic [1:0] opcode_aste;
    logic       loaded_aste;
    logic       destruido_aste;
    logic       carry_som_sub;
    // Datapath control
    logic       conta_contador_aste;
    logic       reset_contador_aste;
    logic [1:0] select_mux_pos_aste;
    logic       select_mux_coor_aste;
    logic       select_soma_sub_aste;
    logic       enable_mem_aste;
    logic       enable_load_aste;
    logic       new_load_aste;
    logic       new_destruido_aste;
    logic       reset_reg_nave;
    logic       reset_gerador_random;

    modport master (
        input  colisao_aste_com_nave, rco_contador_aste, opcode_aste, loaded_aste,
               destruido_aste, carry_som_sub,
        output conta_contador_aste, reset_contador_aste, select_mux_pos_aste,
               select_mux_coor_aste, select_soma_sub_aste, enable_mem_aste, enable_load_aste,
               new_load_aste, new_destruido_aste, reset_reg_nave, reset_gerador_random
    );

    modport slave (
        output colisao_aste_com_nave, rco_contador_aste, opcode_aste, loaded_aste,
               destruido_aste, carry_som_sub,
        input  conta_contador_aste, reset_contador_aste, select_mux_pos_aste,
               select_mux_coor_aste, select_soma_sub_aste, enable_mem_aste, enable_load_aste,
               new_load_aste, new_destruido_aste, reset_reg_nave, reset_gerador_random
    );
endinterface

// File: rtl/uc_asteroide.sv
// Control FSM for the asteroid datapath: per-tick move sweep over all slots and spawn into a free slot.
// Optional macro UC_ASTE_WRAP_EN: coordinates wrap 15<->0 instead of the asteroid dying at the edge.
module uc_asteroide #(
    parameter int unsigned N_ASTE   = 16,
    parameter int unsigned ESTADO_W = 4
) (
    input  logic                clock,
    input  logic                reset_n,
    input  logic                tick_move,
    input  logic                spawn_req,
    uc_asteroide_if.master      dp,
    output logic                busy,
    output logic                colisao,
    output logic                spawn_ok,
    output logic                spawn_fail,
    output logic [ESTADO_W-1:0] db_estado
);

    // The sweep ends on the datapath's rco, which only covers a 4-bit slot counter.
    if (N_ASTE < 1 || N_ASTE > 16) begin : g_bad_n_aste
        $error("uc_asteroide: N_ASTE must be in 1..16");
    end

    typedef enum logic [3:0] {
        StInicial = 4'd0,
        StOcioso  = 4'd1,
        StZeraM   = 4'd2,
        StLeM     = 4'd3,
        StAvalia  = 4'd4,
        StMove    = 4'd5,
        StLeC     = 4'd6,
        StChecaC  = 4'd7,
        StMata    = 4'd8,
        StProxM   = 4'd9,
        StZeraS   = 4'd10,
        StLeS     = 4'd11,
        StBusca   = 4'd12,
        StGrava   = 4'd13
    } estado_e;

    estado_e state_q, state_d;
    logic    pend_move_q, pend_move_d;
    logic    pend_spawn_q, pend_spawn_d;
    logic    want_move, want_spawn;
    logic    clr_move, clr_spawn;

    // A request seen while idle is served at once; otherwise it waits in the pending flag.
    assign want_move  = pend_move_q | tick_move;
    assign want_spawn = pend_spawn_q | spawn_req;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= StInicial;
            pend_move_q  <= 1'b0;
            pend_spawn_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            pend_move_q  <= pend_move_d;
            pend_spawn_q <= pend_spawn_d;
        end
    end

    assign pend_move_d  = want_move & ~clr_move;
    assign pend_spawn_d = want_spawn & ~clr_spawn;

    always_comb begin
        state_d                 = state_q;
        clr_move                = 1'b0;
        clr_spawn               = 1'b0;
        dp.conta_contador_aste  = 1'b0;
        dp.reset_contador_aste  = 1'b0;
        dp.select_mux_pos_aste  = 2'b00;
        dp.select_mux_coor_aste = 1'b0;
        dp.select_soma_sub_aste = 1'b0;
        dp.enable_mem_aste      = 1'b0;
        dp.enable_load_aste     = 1'b0;
        dp.new_load_aste        = 1'b0;
        dp.new_destruido_aste   = 1'b0;
        dp.reset_reg_nave       = 1'b0;
        dp.reset_gerador_random = 1'b0;
        colisao                 = 1'b0;
        spawn_ok                = 1'b0;
        spawn_fail              = 1'b0;
        busy                    = (state_q != StInicial) && (state_q != StOcioso);
        db_estado               = ESTADO_W'(state_q);

        unique case (state_q)
            StInicial: begin
                // Ship/random init strobes stay low while reset is still held.
                dp.reset_reg_nave       = reset_n;
                dp.reset_gerador_random = reset_n;
                dp.reset_contador_aste  = 1'b1;
                state_d                 = StOcioso;
            end
            StOcioso: begin
                if (want_move) begin
                    clr_move = 1'b1;
                    state_d  = StZeraM;
                end else if (want_spawn) begin
                    clr_spawn = 1'b1;
                    state_d   = StZeraS;
                end
            end
            StZeraM: begin
                dp.reset_contador_aste = 1'b1;
                state_d                = StLeM;
            end
            StLeM:    state_d = StAvalia;
            StAvalia: state_d = (dp.loaded_aste && !dp.destruido_aste) ? StMove : StProxM;
            StMove: begin
                dp.select_mux_coor_aste = dp.opcode_aste[1];
                dp.select_soma_sub_aste = dp.opcode_aste[0];
                dp.select_mux_pos_aste  = {1'b0, dp.opcode_aste[1]};
                dp.enable_mem_aste      = 1'b1;
`ifdef UC_ASTE_WRAP_EN
                state_d = StLeC;
`else
                state_d = dp.carry_som_sub ? StMata : StLeC;
`endif
            end
            StLeC: state_d = StChecaC;
            StChecaC: begin
                if (dp.colisao_aste_com_nave) begin
                    colisao = 1'b1;
                    state_d = StMata;
                end else begin
                    state_d = StProxM;
                end
            end
            StMata: begin
                dp.enable_load_aste   = 1'b1;
                dp.new_destruido_aste = 1'b1;
                state_d               = StProxM;
            end
            StProxM: begin
                if (dp.rco_contador_aste) begin
                    state_d = StOcioso;
                end else begin
                    dp.conta_contador_aste = 1'b1;
                    state_d                = StLeM;
                end
            end
            StZeraS: begin
                dp.reset_contador_aste = 1'b1;
                state_d                = StLeS;
            end
            StLeS: state_d = StBusca;
            StBusca: begin
                // A destroyed slot that is still marked loaded does not count as free.
                if (!dp.loaded_aste) begin
                    state_d = StGrava;
                end else if (dp.rco_contador_aste) begin
                    spawn_fail = 1'b1;
                    state_d    = StOcioso;
                end else begin
                    dp.conta_contador_aste = 1'b1;
                    state_d                = StLeS;
                end
            end
            StGrava: begin
                dp.select_mux_pos_aste = 2'b10;
                dp.enable_mem_aste     = 1'b1;
                dp.enable_load_aste    = 1'b1;
                dp.new_load_aste       = 1'b1;
                spawn_ok               = 1'b1;
                state_d                = StOcioso;
            end
            default: state_d = StInicial;
        endcase
    end

endmodule

// File: tb/tb_uc_asteroide.sv
// Bench for uc_asteroide: bench-side datapath plus a slot-level reference of sweeps and spawns.
module tb_uc_asteroide;
    logic clock = 1'b0;
    always #5 clock = ~clock;

    logic       reset_n, tick_move, spawn_req;
    logic       busy, colisao, spawn_ok, spawn_fail;
    logic [3:0] db_estado;

    uc_asteroide_if dp ();

    uc_asteroide #(.N_ASTE(16), .ESTADO_W(4)) dut (
        .clock      (clock),
        .reset_n    (reset_n),
        .tick_move  (tick_move),
        .spawn_req  (spawn_req),
        .dp         (dp),
        .busy       (busy),
        .colisao    (colisao),
        .spawn_ok   (spawn_ok),
        .spawn_fail (spawn_fail),
        .db_estado  (db_estado)
    );

    int checks = 0;
    int errors = 0;

    // ---------------- bench datapath: memories, slot counter, adder, comparator
    logic [3:0] mx[16], my[16];
    logic [1:0] mop[16];
    logic       mld[16], mds[16];
    logic [3:0] pre_x[16], pre_y[16];
    logic [1:0] pre_op[16];
    logic       pre_ld[16], pre_ds[16];
    logic       pre_load;
    logic [3:0] cnt, rx, ry, ship_x, ship_y, rnd_x, rnd_y, coord;
    logic [1:0] rop, rnd_op;
    logic       rld, rds;
    logic [4:0] sum;

    always_comb begin
        coord = dp.select_mux_coor_aste ? ry : rx;
        sum   = dp.select_soma_sub_aste ? {1'b0, coord} - 5'd1 : {1'b0, coord} + 5'd1;
    end

    assign dp.loaded_aste           = rld;
    assign dp.destruido_aste        = rds;
    assign dp.opcode_aste           = rop;
    assign dp.rco_contador_aste     = (cnt == 4'd15);
    assign dp.colisao_aste_com_nave = (rx == ship_x) && (ry == ship_y);
    assign dp.carry_som_sub         = sum[4];

    always @(posedge clock) begin
        rx  <= mx[cnt];
        ry  <= my[cnt];
        rop <= mop[cnt];
        rld <= mld[cnt];
        rds <= mds[cnt];
        if (pre_load) begin
            for (int i = 0; i < 16; i++) begin
                mx[i]  <= pre_x[i];
                my[i]  <= pre_y[i];
                mop[i] <= pre_op[i];
                mld[i] <= pre_ld[i];
                mds[i] <= pre_ds[i];
            end
        end else begin
            if (dp.enable_mem_aste) begin
                case (dp.select_mux_pos_aste)
                    2'b00:   mx[cnt] <= sum[3:0];
                    2'b01:   my[cnt] <= sum[3:0];
                    2'b10: begin
                        mx[cnt]  <= rnd_x;
                        my[cnt]  <= rnd_y;
                        mop[cnt] <= rnd_op;
                    end
                    default: ;
                endcase
            end
            if (dp.enable_load_aste) begin
                mld[cnt] <= dp.new_load_aste;
                mds[cnt] <= dp.new_destruido_aste;
            end
        end
        if (dp.reset_contador_aste)      cnt <= 4'd0;
        else if (dp.conta_contador_aste) cnt <= cnt + 4'd1;
    end

    // ---------------- every-cycle output rules
    always @(negedge clock) begin
        if (reset_n) begin
            checks++;
            if (dp.conta_contador_aste && dp.reset_contador_aste) begin
                errors++;
                $display("FAIL counter strobes: conta and reset both 1 at %0t", $time);
            end
            checks++;
            if (!busy && (db_estado > 4'd1 || dp.enable_mem_aste || dp.enable_load_aste ||
                          colisao || spawn_ok || spawn_fail || dp.conta_contador_aste)) begin
                errors++;
                $display("FAIL idle outputs: db_estado=%0d mem=%0b load=%0b at %0t required idle",
                         db_estado, dp.enable_mem_aste, dp.enable_load_aste, $time);
            end
        end
    end

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    // ---------------- slot-level reference
    int ref_x[16], ref_y[16], ref_op[16];
    bit ref_ld[16], ref_ds[16];

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d required %0d", name, act, exp);
        end
    endtask

    task automatic ref_kill(input int i);
        ref_ld[i] = 1'b0;
        ref_ds[i] = 1'b1;
    endtask

    // Busy cycles: 1 to clear the counter, then 3/6/7 per idle/moved/moved+killed slot, 5 for edge kill.
    task automatic ref_sweep(output int cyc, output int ncol);
        cyc  = 1;
        ncol = 0;
        for (int i = 0; i < 16; i++) begin
            int c, n;
            bit use_y, off;
            if (!(ref_ld[i] && !ref_ds[i])) begin
                cyc += 3;
                continue;
            end
            use_y = (ref_op[i] >= 2);
            c     = use_y ? ref_y[i] : ref_x[i];
            n     = (ref_op[i] % 2 == 1) ? c - 1 : c + 1;
            off   = (n < 0) || (n > 15);
            n     = (n + 16) % 16;
            if (use_y) ref_y[i] = n;
            else       ref_x[i] = n;
`ifdef UC_ASTE_WRAP_EN
            off = 1'b0;
`endif
            if (off) begin
                ref_kill(i);
                cyc += 5;
            end else if (ref_x[i] == int'(ship_x) && ref_y[i] == int'(ship_y)) begin
                ref_kill(i);
                ncol++;
                cyc += 7;
            end else begin
                cyc += 6;
            end
        end
    endtask

    task automatic ref_spawn(output int cyc, output bit ok);
        int k = 16;
        for (int i = 15; i >= 0; i--) if (!ref_ld[i]) k = i;
        ok = (k < 16);
        if (ok) begin
            ref_x[k]  = int'(rnd_x);
            ref_y[k]  = int'(rnd_y);
            ref_op[k] = int'(rnd_op);
            ref_ld[k] = 1'b1;
            ref_ds[k] = 1'b0;
            cyc       = 4 + 2 * k;
        end else begin
            cyc = 33;
        end
    endtask

    task automatic clear_ref();
        for (int i = 0; i < 16; i++) begin
            ref_x[i] = 0; ref_y[i] = 0; ref_op[i] = 0; ref_ld[i] = 0; ref_ds[i] = 0;
        end
    endtask

    task automatic rand_ref();
        int j, c;
        for (int i = 0; i < 16; i++) begin
            ref_x[i]  = $urandom_range(0, 15);
            ref_y[i]  = $urandom_range(0, 15);
            ref_op[i] = $urandom_range(0, 3);
            ref_ld[i] = ($urandom_range(0, 9) < 7);
            ref_ds[i] = ($urandom_range(0, 9) < 2);
        end
        // Put the ship on one asteroid's next cell so collisions actually happen.
        j      = $urandom_range(0, 15);
        ship_x = 4'(ref_x[j]);
        ship_y = 4'(ref_y[j]);
        c      = (ref_op[j] % 2 == 1) ? 15 : 1;
        if (ref_op[j] >= 2) ship_y = ship_y + 4'(c);
        else                ship_x = ship_x + 4'(c);
    endtask

    task automatic preload();
        for (int i = 0; i < 16; i++) begin
            pre_x[i]  = 4'(ref_x[i]);
            pre_y[i]  = 4'(ref_y[i]);
            pre_op[i] = 2'(ref_op[i]);
            pre_ld[i] = ref_ld[i];
            pre_ds[i] = ref_ds[i];
        end
        @(negedge clock) pre_load = 1'b1;
        @(negedge clock) pre_load = 1'b0;
    endtask

    task automatic check_mem(input string name);
        for (int i = 0; i < 16; i++) begin
            logic [11:0] act;
            int exp;
            act = {mx[i], my[i], mop[i], mld[i], mds[i]};
            exp = (ref_x[i] << 8) | (ref_y[i] << 4) | (ref_op[i] << 2) |
                  (int'(ref_ld[i]) << 1) | int'(ref_ds[i]);
            chk($sformatf("%s slot %0d {x,y,op,ld,ds}", name, i), int'(act), exp);
        end
    endtask

    // Counts one busy episode, sampling outputs on falling edges.
    task automatic run_txn(output int cyc, output int ncol, output int nok, output int nfail,
                           output int nstrobe, output bit seen);
        cyc = 0; ncol = 0; nok = 0; nfail = 0; nstrobe = 0;
        for (int k = 0; k < 4 && !busy; k++) @(negedge clock);
        seen = busy;
        while (busy && cyc < 2000) begin
            cyc++;
            ncol    += int'(colisao);
            nok     += int'(spawn_ok);
            nfail   += int'(spawn_fail);
            nstrobe += int'(dp.enable_mem_aste | dp.enable_load_aste);
            @(negedge clock);
        end
    endtask

    task automatic new_rnd();
        rnd_x  = 4'($urandom_range(0, 15));
        rnd_y  = 4'($urandom_range(0, 15));
        rnd_op = 2'($urandom_range(0, 3));
    endtask

    task automatic pulse(input bit mv, input bit sp);
        @(negedge clock);
        tick_move = mv;
        spawn_req = sp;
        @(negedge clock);
        tick_move = 1'b0;
        spawn_req = 1'b0;
    endtask

    task automatic check_sweep(input string name, input int ecyc, input int ecol,
                               output int cyc, output int ncol);
        int nok, nfail, nstr;
        bit seen;
        run_txn(cyc, ncol, nok, nfail, nstr, seen);
        chk({name, " sweep started"}, int'(seen), 1);
        chk({name, " sweep cycles"}, cyc, ecyc);
        chk({name, " collisions"}, ncol, ecol);
    endtask

    task automatic check_spawn(input string name, input int ecyc, input bit eok, output int cyc);
        int ncol, nok, nfail, nstr;
        bit seen;
        run_txn(cyc, ncol, nok, nfail, nstr, seen);
        chk({name, " spawn started"}, int'(seen), 1);
        chk({name, " spawn cycles"}, cyc, ecyc);
        chk({name, " spawn_ok"}, nok, int'(eok));
        chk({name, " spawn_fail"}, nfail, int'(!eok));
        if (!eok) chk({name, " write strobes on fail"}, nstr, 0);
    endtask

    task automatic do_sweep(input string name, output int cyc, output int ncol);
        int ecyc, ecol;
        ref_sweep(ecyc, ecol);
        pulse(1'b1, 1'b0);
        check_sweep(name, ecyc, ecol, cyc, ncol);
        check_mem(name);
    endtask

    task automatic do_spawn(input string name, output int cyc);
        int  ecyc;
        bit  eok;
        new_rnd();
        ref_spawn(ecyc, eok);
        pulse(1'b0, 1'b1);
        check_spawn(name, ecyc, eok, cyc);
        check_mem(name);
    endtask

    task automatic do_both(input string name);
        int ecyc, ecol, scyc, cyc, ncol;
        bit eok;
        new_rnd();
        ref_sweep(ecyc, ecol);
        ref_spawn(scyc, eok);
        pulse(1'b1, 1'b1);
        check_sweep(name, ecyc, ecol, cyc, ncol);
        check_spawn(name, scyc, eok, cyc);
        check_mem(name);
    endtask

    initial begin
        int cyc, ncol, nbusy;
        reset_n   = 1'b0;
        tick_move = 1'b0;
        spawn_req = 1'b0;
        pre_load  = 1'b0;
        ship_x    = 4'd12;
        ship_y    = 4'd12;
        rnd_x     = 4'd0;
        rnd_y     = 4'd0;
        rnd_op    = 2'd0;
        clear_ref();
        preload();

        // Reset held: only the counter clear is active.
        @(negedge clock);
        chk("reset db_estado", int'(db_estado), 0);
        chk("reset busy", int'(busy), 0);
        chk("reset reset_contador", int'(dp.reset_contador_aste), 1);
        chk("reset reset_reg_nave", int'(dp.reset_reg_nave), 0);
        chk("reset enable_mem", int'(dp.enable_mem_aste), 0);
        reset_n = 1'b1;
        #1;
        chk("inicial reset_reg_nave", int'(dp.reset_reg_nave), 1);
        chk("inicial reset_gerador_random", int'(dp.reset_gerador_random), 1);
        chk("inicial reset_contador", int'(dp.reset_contador_aste), 1);
        @(negedge clock);
        chk("ocioso db_estado", int'(db_estado), 1);
        chk("ocioso busy", int'(busy), 0);
        chk("ocioso reset_reg_nave", int'(dp.reset_reg_nave), 0);

        // Fill all slots, then one more must fail.
        for (int k = 0; k < 16; k++) begin
            do_spawn($sformatf("fill %0d", k), cyc);
            if (k == 0) chk("first spawn latency literal", cyc, 4);
        end
        do_spawn("spawn when full", cyc);
        chk("full spawn latency literal", cyc, 33);

        // Slot 3 moves x+1.
        clear_ref();
        ref_x[3] = 5; ref_y[3] = 7; ref_op[3] = 0; ref_ld[3] = 1;
        ship_x = 4'd12; ship_y = 4'd12;
        preload();
        do_sweep("slot3 move", cyc, ncol);
        chk("slot3 x literal", int'(mx[3]), 6);
        chk("slot3 y literal", int'(my[3]), 7);
        chk("slot3 latency literal", cyc, 52);

        // Move onto the ship.
        clear_ref();
        ref_x[5] = 6; ref_y[5] = 7; ref_op[5] = 0; ref_ld[5] = 1;
        ship_x = 4'd7; ship_y = 4'd7;
        preload();
        do_sweep("collision", cyc, ncol);
        chk("collision pulses literal", ncol, 1);
        chk("collision loaded literal", int'(mld[5]), 0);
        chk("collision destroyed literal", int'(mds[5]), 1);
        chk("collision latency literal", cyc, 53);

        // Edge of the grid.
        clear_ref();
        ref_x[9] = 15; ref_y[9] = 3; ref_op[9] = 0; ref_ld[9] = 1;
        ship_x = 4'd8; ship_y = 4'd8;
        preload();
        do_sweep("edge", cyc, ncol);
`ifdef UC_ASTE_WRAP_EN
        chk("edge wrapped x literal", int'(mx[9]), 0);
        chk("edge still loaded literal", int'(mld[9]), 1);
        chk("edge latency literal", cyc, 52);
`else
        chk("edge destroyed literal", int'(mds[9]), 1);
        chk("edge unloaded literal", int'(mld[9]), 0);
        chk("edge latency literal", cyc, 51);
`endif

        // Randomized sweeps, spawns and simultaneous requests.
        for (int it = 0; it < 10; it++) begin
            rand_ref();
            preload();
            case ($urandom_range(0, 2))
                0: do_sweep($sformatf("rand %0d", it), cyc, ncol);
                1: do_both($sformatf("rand both %0d", it));
                default: begin
                    do_spawn($sformatf("rand spawn %0d", it), cyc);
                    do_sweep($sformatf("rand sweep %0d", it), cyc, ncol);
                end
            endcase
        end

        // Reset mid-sweep abandons the sweep and drops a pending spawn.
        rand_ref();
        for (int i = 0; i < 16; i++) begin ref_ld[i] = 1; ref_ds[i] = 0; end
        preload();
        pulse(1'b1, 1'b0);
        repeat (8) @(negedge clock);
        spawn_req = 1'b1;
        @(negedge clock);
        spawn_req = 1'b0;
        repeat (4) @(negedge clock);
        reset_n = 1'b0;
        #1;
        chk("mid reset db_estado", int'(db_estado), 0);
        chk("mid reset busy", int'(busy), 0);
        repeat (2) @(negedge clock);
        reset_n = 1'b1;
        @(negedge clock);
        chk("after mid reset db_estado", int'(db_estado), 1);
        nbusy = 0;
        repeat (8) begin
            @(negedge clock);
            nbusy += int'(busy);
        end
        chk("no resumed work after reset", nbusy, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
